twiddle_cos_table: RTL and testbench
====================================

// Module: twiddle_cos_table
// PURPOSE
//  Responder side of the quarter-wave twiddle ROM interface (twact/twa -> twdr_cos).
//  After reset it fills an internal RAM with cos(2*pi*k/2^FFT_N), k = 0..2^(FFT_N-2)-1,
//  using an iterative CORDIC. It then serves reads with 1-cycle latency to the twiddle bridge.
//  This replaces the precomputed ROM image, so table contents always track FFT_N/FFT_DW.
// PARAMETERS
//  FFT_N   10         log2 FFT length; table depth NE = 2^(FFT_N-2)
//  FFT_DW  16         unsigned magnitude width of table entries
//  ITER    FFT_DW+2   CORDIC iterations per entry
//  GW      4          CORDIC guard bits (internal x/y width FFT_DW+GW+2, signed)
// PORTS
//  clk       in   1          clock
//  rst       in   1          synchronous reset, active-high
//  init_req  in   1          pulse: regenerate table (honoured only when ready=1)
//  ready     out  1          table valid; reads are served
//  twact     in   1          read strobe
//  twa       in   FFT_N-2    read address k
//  twdr_cos  out  FFT_DW     read data, valid the cycle after twact
//  rd_err    out  1          sticky: a read arrived while ready=0; cleared by rst or init_req
// BEHAVIOUR
//  Reset: ready=0, twdr_cos=0, rd_err=0, FSM=S_LOAD, k=0. RAM contents are undefined until rewritten.
//  Scale: A = 2^FFT_DW-1. entry[k] = round(A*cos(pi/2*k/NE)). Tolerance |err| <= 2 LSB.
//   entry[0] is forced to exactly A.
//  Angle z: unsigned fraction of a quarter turn, z0 = k << (ZW-(FFT_N-2)). The atan table uses the same units.
//  FSM per entry (ITER+2 cycles):
//   S_LOAD: x=K^-1*A (package constant, including guard bits), y=0, z=z0; iteration i=0.
//   S_ITER: ITER cycles. d = sign(z); x -= d*(y>>>i); y += d*(x>>>i); z -= d*atan[i].
//   S_WRITE: round x (drop GW, round half up), clamp to [0,A], write RAM[k].
//     If k = NE-1 -> S_READY, else k++ and -> S_LOAD.
//   S_READY: ready=1. An init_req pulse -> S_LOAD with k=0; ready drops the next cycle and rd_err clears.
//  Fill time: ready rises exactly NE*(ITER+2) cycles after the first cycle with rst=0
//   (5120 cycles at defaults).
//  Reads:
//   - twact=1 with ready=1: twdr_cos <= RAM[twa] on the next edge.
//   - twact=0: twdr_cos holds its value.
//   - twact=1 with ready=0: twdr_cos <= 0 and rd_err <= 1.
//   Back-to-back reads are allowed every cycle (the bridge issues cos, then sin, on consecutive cycles).
//  twa = 0 reached through the bridge's sin wrap is a legal read of entry[0]; the bridge zeroes it itself.
//  Simultaneous events:
//   - twact and init_req in the same READY cycle: the read is served, then regeneration starts.
//   - init_req outside S_READY is ignored.
//  rst mid-fill or mid-read: abort immediately, restart from k=0, and apply the reset outputs above.
//  The RAM has a single write port (FSM) and a single read port. Write and read are never
//   active together, because reads are served only in S_READY.
// STRUCTURE
//  twiddle_pkg:
//   - state enum {S_LOAD,S_ITER,S_WRITE,S_READY}
//   - function atan_q(i), returning the quarter-turn fraction of atan(2^-i)
//   - CORDIC_INV_GAIN constant
//   - derived widths NE, ZW = FFT_DW+4, XW
//  Sub-module twiddle_cordic_iter: combinational single micro-rotation (x,y,z,i -> x',y',z').
//   Registers live in the top level. Table storage is an inferred synchronous-read RAM, NE x FFT_DW.
// TESTING
//  1. Release rst, wait: ready=0 for exactly 5119 cycles after release, ready=1 at cycle 5120.
//  2. Full sweep of twa=0..255: each twdr_cos within +/-2 of round(65535*cos(pi*k/512)).
//     entry 0 = 65535; entry 128 in 46338..46342; entry 255 in 400..404.
//  3. twact with twa=128 at cycle t during fill: twdr_cos=0 at t+1, rd_err=1 sticky.
//     After ready, a read at twa=0 returns 65535 at the next cycle.
//  4. Back-to-back twact (twa=5, then 251, then idle): data at t+1 and t+2 match entries 5 and 251.
//     At t+3, twdr_cos still equals entry 251.
//  5. init_req in READY together with twact twa=7: entry 7 returned, ready=0 next cycle, rd_err cleared.
//     ready returns 5120 cycles later with an identical table.
//  6. Assert rst at entry k=100 mid-S_ITER: outputs reset.
//     Table fully correct 5120 cycles after release (compare against the scoreboard).

Source files
------------

// File: rtl/twiddle_pkg.sv
// Shared types and elaboration-time helpers for the CORDIC-filled quarter-wave cosine table.
package twiddle_pkg;

  typedef enum logic [1:0] {
    S_LOAD,
    S_ITER,
    S_WRITE,
    S_READY
  } state_t;

  localparam real PI              = 3.14159265358979323846;
  // Converged CORDIC gain reciprocal; the residual for >= 16 iterations is far below one LSB.
  localparam real CORDIC_INV_GAIN = 0.60725293500888125617;

  // Table depth for a 2^fft_n point transform (one quarter wave).
  function automatic int ne_of(input int fft_n);
    return 1 << (fft_n - 2);
  endfunction

  // Angle width: unsigned fraction of a quarter turn.
  function automatic int zw_of(input int fft_dw);
    return fft_dw + 4;
  endfunction

  // Signed x/y datapath width including guard bits and growth headroom.
  function automatic int xw_of(input int fft_dw, input int gw);
    return fft_dw + gw + 2;
  endfunction

  // atan(2^-i) as a fraction of a quarter turn, scaled by 2^zw and rounded.
  function automatic longint atan_q(input int i, input int zw = 20);
    real a;
    a = $atan(2.0 ** (-i)) / (PI / 2.0) * (2.0 ** zw);
    return longint'(a);
  endfunction

  // Start value of x: full-scale amplitude with guard bits, pre-divided by the CORDIC gain.
  function automatic longint cordic_x0(input int fft_dw, input int gw);
    real v;
    v = ((2.0 ** fft_dw) - 1.0) * (2.0 ** gw) * CORDIC_INV_GAIN;
    return longint'(v);
  endfunction

endpackage

// File: rtl/twiddle_cordic_iter.sv
// One combinational CORDIC micro-rotation in rotation mode; state registers live in the caller.
module twiddle_cordic_iter
  import twiddle_pkg::*;
#(
  parameter int XW   = 22,
  parameter int ZW   = 20,
  parameter int ZSW  = 22,
  parameter int ITER = 18,
  parameter int IW   = 5
) (
  input  logic signed [XW-1:0]  x,
  input  logic signed [XW-1:0]  y,
  input  logic signed [ZSW-1:0] z,
  input  logic [IW-1:0]         i,
  output logic signed [XW-1:0]  x_next,
  output logic signed [XW-1:0]  y_next,
  output logic signed [ZSW-1:0] z_next
);

  logic [ZW-1:0]         atan_tab [ITER];
  logic signed [XW-1:0]  x_sh;
  logic signed [XW-1:0]  y_sh;
  logic signed [ZSW-1:0] a_step;

  generate
    for (genvar gi = 0; gi < ITER; gi++) begin : g_atan
      localparam longint ATAN_Q = atan_q(gi, ZW);
      assign atan_tab[gi] = ZW'(ATAN_Q);
    end
  endgenerate

  always_comb begin
    x_sh   = x >>> i;
    y_sh   = y >>> i;
    a_step = $signed({{(ZSW-ZW){1'b0}}, atan_tab[i]});
    // Residual angle sign picks the rotation direction.
    if (!z[ZSW-1]) begin
      x_next = x - y_sh;
      y_next = y + x_sh;
      z_next = z - a_step;
    end else begin
      x_next = x + y_sh;
      y_next = y - x_sh;
      z_next = z + a_step;
    end
  end

endmodule

// File: rtl/twiddle_cos_table.sv
// Quarter-wave cosine twiddle table: fills its RAM with CORDIC after reset, then serves 1-cycle reads.
module twiddle_cos_table
  import twiddle_pkg::*;
#(
  parameter int FFT_N  = 10,
  parameter int FFT_DW = 16,
  parameter int ITER   = FFT_DW + 2,
  parameter int GW     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init_req,
  output logic              ready,
  input  logic              twact,
  input  logic [FFT_N-3:0]  twa,
  output logic [FFT_DW-1:0] twdr_cos,
  output logic              rd_err
);

  localparam int KW  = FFT_N - 2;
  localparam int NE  = ne_of(FFT_N);
  localparam int ZW  = zw_of(FFT_DW);
  localparam int ZSW = ZW + 2;
  localparam int XW  = xw_of(FFT_DW, GW);
  localparam int IW  = (ITER > 1) ? $clog2(ITER) : 1;

  localparam logic [FFT_DW-1:0]  A      = {FFT_DW{1'b1}};
  localparam logic signed [XW-1:0] A_S  = $signed({{(XW-FFT_DW){1'b0}}, A});
  localparam logic signed [XW-1:0] X0   = XW'(cordic_x0(FFT_DW, GW));
  localparam logic signed [XW-1:0] RND  = XW'(longint'(1) << (GW - 1));
  localparam logic [KW-1:0]        K_LAST = KW'(NE - 1);
  localparam logic [IW-1:0]        I_LAST = IW'(ITER - 1);

  state_t                state_reg;
  logic [KW-1:0]         k_reg;
  logic [IW-1:0]         i_reg;
  logic signed [XW-1:0]  x_reg;
  logic signed [XW-1:0]  y_reg;
  logic signed [ZSW-1:0] z_reg;

  logic signed [XW-1:0]  x_next;
  logic signed [XW-1:0]  y_next;
  logic signed [ZSW-1:0] z_next;
  logic signed [ZSW-1:0] z_start;
  logic signed [XW-1:0]  x_rnd;
  logic signed [XW-1:0]  x_int;
  logic [FFT_DW-1:0]     wr_data;
  logic                  wr_en;

  logic [FFT_DW-1:0]     ram_mem [NE];

  twiddle_cordic_iter #(
    .XW   (XW),
    .ZW   (ZW),
    .ZSW  (ZSW),
    .ITER (ITER),
    .IW   (IW)
  ) u_iter (
    .x      (x_reg),
    .y      (y_reg),
    .z      (z_reg),
    .i      (i_reg),
    .x_next (x_next),
    .y_next (y_next),
    .z_next (z_next)
  );

  // Entry k sits at angle k/NE of a quarter turn.
  assign z_start = $signed({{(ZSW-ZW){1'b0}}, k_reg, {(ZW-KW){1'b0}}});

  always_comb begin
    x_rnd = x_reg + RND;
    x_int = x_rnd >>> GW;
    if (k_reg == '0) begin
      wr_data = A;
    end else if (x_int[XW-1]) begin
      wr_data = '0;
    end else if (x_int > A_S) begin
      wr_data = A;
    end else begin
      wr_data = x_int[FFT_DW-1:0];
    end
  end

  assign wr_en = (state_reg == S_WRITE) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_LOAD;
      k_reg     <= '0;
      i_reg     <= '0;
      x_reg     <= '0;
      y_reg     <= '0;
      z_reg     <= '0;
      ready     <= 1'b0;
      rd_err    <= 1'b0;
    end else begin
      if (twact && !ready) begin
        rd_err <= 1'b1;
      end
      case (state_reg)
        S_LOAD: begin
          x_reg     <= X0;
          y_reg     <= '0;
          z_reg     <= z_start;
          i_reg     <= '0;
          state_reg <= S_ITER;
        end
        S_ITER: begin
          x_reg <= x_next;
          y_reg <= y_next;
          z_reg <= z_next;
          i_reg <= i_reg + IW'(1);
          if (i_reg == I_LAST) begin
            state_reg <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (k_reg == K_LAST) begin
            state_reg <= S_READY;
            ready     <= 1'b1;
          end else begin
            k_reg     <= k_reg + KW'(1);
            state_reg <= S_LOAD;
          end
        end
        S_READY: begin
          if (init_req) begin
            state_reg <= S_LOAD;
            k_reg     <= '0;
            ready     <= 1'b0;
            rd_err    <= 1'b0;
          end
        end
        default: begin
          state_reg <= S_LOAD;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      ram_mem[k_reg] <= wr_data;
    end
  end

  // Reads only happen in S_READY, so they never collide with the fill writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      twdr_cos <= '0;
    end else if (twact) begin
      if (ready) begin
        twdr_cos <= ram_mem[twa];
      end else begin
        twdr_cos <= '0;
      end
    end
  end

endmodule

// File: tb/tb_twiddle_cos_table.sv
// Scoreboard bench for twiddle_cos_table: fill timing, full-table sweeps, error reads, regeneration, reset.
module tb_twiddle_cos_table;

  localparam int NE         = 256;
  localparam int FILL_CYC   = 5120;
  localparam int FILL_LIMIT = 6000;

  typedef struct {
    int addr;
    int lo;
    int hi;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       init_req;
  logic       ready;
  logic       twact;
  logic [7:0] twa;
  logic [15:0] twdr_cos;
  logic       rd_err;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb_q[$];
  bit   rd_pend = 1'b0;

  twiddle_cos_table dut (
    .clk      (clk),
    .rst      (rst),
    .init_req (init_req),
    .ready    (ready),
    .twact    (twact),
    .twa      (twa),
    .twdr_cos (twdr_cos),
    .rd_err   (rd_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint lo, input longint hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Reference: round(65535*cos(pi*k/512)) +/- 2, with the hand-computed anchor points.
  function automatic exp_t model(input int k);
    exp_t e;
    real  v;
    int   r;
    v = 65535.0 * $cos(3.141592653589793 * k / 512.0);
    r = $rtoi(v + 0.5);
    e.addr = k;
    e.lo   = r - 2;
    e.hi   = r + 2;
    if (k == 0) begin
      e.lo = 65535;
      e.hi = 65535;
    end else if (k == 128) begin
      e.lo = 46338;
      e.hi = 46342;
    end else if (k == 255) begin
      e.lo = 400;
      e.hi = 404;
    end
    return e;
  endfunction

  function automatic exp_t zero_exp(input int k);
    exp_t e;
    e.addr = k;
    e.lo   = 0;
    e.hi   = 0;
    return e;
  endfunction

  // Monitor: a read sampled on a rising edge is checked on the following falling edge.
  always @(posedge clk) rd_pend <= twact;

  always @(negedge clk) begin
    exp_t e;
    if (rd_pend) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL rd_unexpected: got data %0d, expected no read", twdr_cos);
      end else begin
        e = sb_q.pop_front();
        $display("read addr=%0d data=%0d expect %0d..%0d", e.addr, twdr_cos, e.lo, e.hi);
        chk($sformatf("rd_data[%0d]", e.addr), twdr_cos, e.lo, e.hi);
      end
    end
  end

  task automatic read_one(input int k, input exp_t e);
    twact = 1'b1;
    twa   = 8'(k);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    twact = 1'b0;
  endtask

  // Counts edges until ready rises; optionally issues one read while not ready.
  task automatic fill_and_time(input string name, input int bad_at);
    int n;
    n = 0;
    while (!ready && n < FILL_LIMIT) begin
      if (n == bad_at) begin
        twact = 1'b1;
        twa   = 8'd128;
        sb_q.push_back(zero_exp(128));
      end
      @(posedge clk);
      #1;
      twact = 1'b0;
      n++;
    end
    chk(name, n, FILL_CYC, FILL_CYC);
  endtask

  task automatic sweep();
    for (int k = 0; k < NE; k++) begin
      twact = 1'b1;
      twa   = 8'(k);
      sb_q.push_back(model(k));
      @(posedge clk);
      #1;
    end
    twact = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    exp_t e251;
    rst      = 1'b1;
    init_req = 1'b0;
    twact    = 1'b0;
    twa      = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", ready, 0, 0);
    chk("rst_data", twdr_cos, 0, 0);
    chk("rst_err", rd_err, 0, 0);

    // Initial fill with one premature read.
    rst = 1'b0;
    fill_and_time("fill_latency", 1000);
    chk("fill_rd_err_sticky", rd_err, 1, 1);
    sweep();
    read_one(0, model(0));
    @(posedge clk);
    #1;

    // Back-to-back reads then idle: data must hold.
    e251 = model(251);
    read_one(5, model(5));
    read_one(251, e251);
    @(posedge clk);
    #1;
    chk("hold_after_idle", twdr_cos, e251.lo, e251.hi);

    // Regeneration requested in the same cycle as a read.
    chk("pre_init_rd_err", rd_err, 1, 1);
    init_req = 1'b1;
    read_one(7, model(7));
    init_req = 1'b0;
    chk("init_ready_drop", ready, 0, 0);
    chk("init_rd_err_clear", rd_err, 0, 0);
    fill_and_time("refill_latency", -1);
    sweep();

    // Reset in the middle of entry 100's iterations.
    init_req = 1'b1;
    @(posedge clk);
    #1;
    init_req = 1'b0;
    repeat (2010) @(posedge clk);
    #1;
    chk("regen_hold_data", twdr_cos, 400, 404);
    chk("regen_not_ready", ready, 0, 0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("midfill_rst_ready", ready, 0, 0);
    chk("midfill_rst_data", twdr_cos, 0, 0);
    chk("midfill_rst_err", rd_err, 0, 0);
    rst = 1'b0;
    fill_and_time("post_rst_latency", -1);
    chk("post_rst_rd_err", rd_err, 0, 0);
    sweep();

    chk("scoreboard_drained", sb_q.size(), 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
